// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives all eight input vectors of a 3-input gate, samples its
// output after a settle time and reports the recovered 8-bit function code.
`timescale 1ns/1ps
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] exp_code,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] code,
    output logic       match
);

    localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e     state_q, state_d;
    logic [7:0] exp_q, exp_d;
    logic [7:0] work_q, work_d;
    logic [2:0] v_q, v_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] code_q, code_d;
    logic       match_q, match_d;
    logic [7:0] shifted;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            exp_q   <= '0;
            work_q  <= '0;
            v_q     <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            work_q  <= work_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            match_q <= match_d;
        end
    end

    // Next-state logic: settle count per vector, shift in sample, publish on final vector.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        work_d  = work_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        match_d = match_q;
        // New sample enters at the LSB so vector 0 ends up in bit 7.
        shifted = {work_q[6:0], dut_out};
        case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    exp_d   = exp_code;
                    work_d  = '0;
                    v_d     = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    // Partial result is dropped; code/match keep the last completed sweep.
                    v_d     = '0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (cnt_q == SettleLast) begin
                    work_d = shifted;
                    cnt_d  = '0;
                    if (v_q == 3'd7) begin
                        code_d  = shifted;
                        match_d = (shifted == exp_q);
                        v_d     = '0;
                        state_d = StDone;
                    end else begin
                        v_d = v_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode: vector only driven while sweeping.
    always_comb begin
        {in1, in2, in3} = (state_q == StRun) ? v_q : 3'b000;
        busy            = (state_q == StRun);
        done            = (state_q == StDone);
        code            = code_q;
        match           = match_q;
    end

endmodule
